// File: rtl/traffic_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_mon_pkg
// Description : Shared types and constants for the traffic-light monitor.
//               - state_t    : FSM encoding. Bits [1:0] of the four non-fault
//                              states equal the externally visible phase code.
//               - FC_*       : latched fault cause codes (0 and 7 reserved).
//               - lamp_pat_t : one-hot decoded lamp pattern.
//               - is_green() : true for the two green-phase states.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_NS_GO   = 3'b001,
        ST_EW_GO   = 3'b010,
        ST_ALL_RED = 3'b011,
        ST_FAULT   = 3'b100
    } state_t;

    localparam logic [2:0] FC_NONE        = 3'd0;
    localparam logic [2:0] FC_CONFLICT    = 3'd1;
    localparam logic [2:0] FC_LAMP        = 3'd2;
    localparam logic [2:0] FC_SHORT       = 3'd3;
    localparam logic [2:0] FC_LONG        = 3'd4;
    localparam logic [2:0] FC_ALLRED_LONG = 3'd5;
    localparam logic [2:0] FC_SEQ         = 3'd6;

    typedef struct packed {
        logic conflict;
        logic lamp_bad;
        logic ns_go;
        logic ew_go;
        logic all_red;
    } lamp_pat_t;

    function automatic logic is_green(input state_t s);
        return (s == ST_NS_GO) || (s == ST_EW_GO);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_lamp_decode.sv
`default_nettype none
// ============================================================================
// Module      : traffic_lamp_decode
// Description : Combinational decode of the four lamp lines into a one-hot
//               pattern, in priority order conflict > lamp_bad > ns_go >
//               ew_go > all_red. Every input combination maps to exactly
//               one pattern bit.
// Ports       : i_ns_red, i_ns_green, i_ew_red, i_ew_green - lamp lines
//               o_pat                                       - decoded pattern
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_lamp_decode
    import traffic_mon_pkg::*;
(
    input  logic      i_ns_red,
    input  logic      i_ns_green,
    input  logic      i_ew_red,
    input  logic      i_ew_green,
    output lamp_pat_t o_pat
);

    logic w_conflict;
    logic w_lamp_bad;

    assign w_conflict = i_ns_green & i_ew_green;
    // Each direction must show exactly one lamp.
    assign w_lamp_bad = ~w_conflict &
                        ((i_ns_red == i_ns_green) | (i_ew_red == i_ew_green));

    always_comb begin
        o_pat          = '0;
        o_pat.conflict = w_conflict;
        o_pat.lamp_bad = w_lamp_bad;
        if (!w_conflict && !w_lamp_bad) begin
            o_pat.ns_go   = i_ns_green & i_ew_red;
            o_pat.ew_go   = i_ew_green & i_ns_red;
            o_pat.all_red = i_ns_red   & i_ew_red;
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive safety/timing checker for a two-direction traffic
//               light. Decodes the lamp pattern every cycle, tracks the phase
//               and its length, counts legal handoffs and latches the first
//               violation (fault/fault_code) until clr_fault.
// Ports       : clk, reset (sync, active-high)
//               NS_red, NS_green, EW_red, EW_green - sampled lamp lines
//               clr_fault  - clears a latched fault (ignored otherwise)
//               fault, fault_code, phase, phase_cnt, handoffs - registered
// Config      : `define TRAFFIC_MON_ALLRED_REQ_EN to require an all-red gap
//               between greens (direct green-to-green and an all-red
//               shorter than MIN_ALLRED both report code 6).
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor
    import traffic_mon_pkg::*;
#(
    parameter int unsigned MIN_GREEN  = 2,
    parameter int unsigned MAX_GREEN  = 8,
    parameter int unsigned MAX_ALLRED = 4,
    parameter int unsigned MIN_ALLRED = 1,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             NS_red,
    input  logic             NS_green,
    input  logic             EW_red,
    input  logic             EW_green,
    input  logic             clr_fault,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] phase_cnt,
    output logic [7:0]       handoffs
);

    localparam int unsigned C_MAX_LEN =
        ((MAX_GREEN > MAX_ALLRED) ? MAX_GREEN : MAX_ALLRED) + 1;

    // Elaboration-time sanity checks on the parameter set.
    if (((1 << CNT_W) - 1) < C_MAX_LEN) begin : g_cnt_w_check
        $error("CNT_W too small to hold the longest checked phase");
    end
    if (MIN_ALLRED > MAX_ALLRED) begin : g_allred_check
        $error("MIN_ALLRED exceeds MAX_ALLRED");
    end

    lamp_pat_t        w_pat;
    state_t           w_pat_state;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [2:0]       w_code;

    state_t           r_state;
    logic             r_fault;
    logic [2:0]       r_code;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_handoffs;
    // Current phase was entered from IDLE, so its start was not observed
    // and minimum-length checks do not apply to it.
    logic             r_from_idle;

    traffic_lamp_decode u_decode (
        .i_ns_red   (NS_red),
        .i_ns_green (NS_green),
        .i_ew_red   (EW_red),
        .i_ew_green (EW_green),
        .o_pat      (w_pat)
    );

    always_comb begin
        w_pat_state = ST_IDLE;
        if (w_pat.ns_go)        w_pat_state = ST_NS_GO;
        else if (w_pat.ew_go)   w_pat_state = ST_EW_GO;
        else if (w_pat.all_red) w_pat_state = ST_ALL_RED;
    end

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // Violation detection for the non-fault states; ignored while in FAULT.
    always_comb begin
        w_code = FC_NONE;
        if (w_pat.conflict) begin
            w_code = FC_CONFLICT;
        end else if (w_pat.lamp_bad) begin
            w_code = FC_LAMP;
        end else if (r_state != ST_IDLE) begin
            if (w_pat_state == r_state) begin
                if (is_green(r_state) && (32'(w_cnt_inc) > MAX_GREEN))
                    w_code = FC_LONG;
                else if ((r_state == ST_ALL_RED) && (32'(w_cnt_inc) > MAX_ALLRED))
                    w_code = FC_ALLRED_LONG;
            end else begin
                if (is_green(r_state) && !r_from_idle && (32'(r_cnt) < MIN_GREEN))
                    w_code = FC_SHORT;
`ifdef TRAFFIC_MON_ALLRED_REQ_EN
                else if (is_green(r_state) && is_green(w_pat_state))
                    w_code = FC_SEQ;
                else if ((r_state == ST_ALL_RED) && !r_from_idle &&
                         (32'(r_cnt) < MIN_ALLRED))
                    w_code = FC_SEQ;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_fault     <= 1'b0;
            r_code      <= FC_NONE;
            r_phase     <= 2'b00;
            r_cnt       <= '0;
            r_handoffs  <= '0;
            r_from_idle <= 1'b0;
        end else if (r_state == ST_FAULT) begin
            // Clear takes priority over anything sampled this cycle; a
            // persisting violation is re-detected from IDLE next cycle.
            if (clr_fault) begin
                r_state     <= ST_IDLE;
                r_fault     <= 1'b0;
                r_code      <= FC_NONE;
                r_phase     <= 2'b00;
                r_cnt       <= '0;
                r_from_idle <= 1'b0;
            end
        end else if (w_code != FC_NONE) begin
            // phase, phase_cnt and handoffs freeze at their pre-fault values.
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
            r_code  <= w_code;
        end else if (r_state == ST_IDLE) begin
            r_state     <= w_pat_state;
            r_phase     <= w_pat_state[1:0];
            r_cnt       <= CNT_W'(1);
            r_from_idle <= 1'b1;
        end else if (w_pat_state == r_state) begin
            r_cnt <= w_cnt_inc;
        end else begin
            r_state     <= w_pat_state;
            r_phase     <= w_pat_state[1:0];
            r_cnt       <= CNT_W'(1);
            r_handoffs  <= r_handoffs + 8'd1;
            r_from_idle <= 1'b0;
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign phase      = r_phase;
    assign phase_cnt  = r_cnt;
    assign handoffs   = r_handoffs;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Directed, self-checking bench for traffic_light_monitor with
//               default parameters. Lamp vectors are {NS_red, NS_green,
//               EW_red, EW_green}; expectations are hand-computed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam logic [3:0] c_ns_go    = 4'b0110;
    localparam logic [3:0] c_ew_go    = 4'b1001;
    localparam logic [3:0] c_all_red  = 4'b1010;
    localparam logic [3:0] c_conflict = 4'b0101;
    localparam logic [3:0] c_lamp_bad = 4'b0010;

    logic       clk = 1'b0;
    logic       reset;
    logic       NS_red, NS_green, EW_red, EW_green;
    logic       clr_fault;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] phase;
    logic [3:0] phase_cnt;
    logic [7:0] handoffs;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    traffic_light_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .NS_red     (NS_red),
        .NS_green   (NS_green),
        .EW_red     (EW_red),
        .EW_green   (EW_green),
        .clr_fault  (clr_fault),
        .fault      (fault),
        .fault_code (fault_code),
        .phase      (phase),
        .phase_cnt  (phase_cnt),
        .handoffs   (handoffs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input int unsigned f, input int unsigned code,
                              input int unsigned ph, input int unsigned cnt, input int unsigned ho);
        check({tag, ".fault"},     32'(fault),      f);
        check({tag, ".fault_code"},32'(fault_code), code);
        check({tag, ".phase"},     32'(phase),      ph);
        check({tag, ".phase_cnt"}, 32'(phase_cnt),  cnt);
        check({tag, ".handoffs"},  32'(handoffs),   ho);
    endtask

    // Present one lamp vector for one clock, then sample 1 time unit later.
    task automatic step(input logic [3:0] lamps, input logic clr);
        {NS_red, NS_green, EW_red, EW_green} = lamps;
        clr_fault = clr;
        @(posedge clk);
        #1;
        clr_fault = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(c_all_red, 1'b0);
        step(c_all_red, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        int ho;
        reset = 1'b1;
        clr_fault = 1'b0;
        {NS_red, NS_green, EW_red, EW_green} = c_all_red;
        #1;

        // Reset state
        do_reset();
        expect_all("reset", 0, 0, 0, 0, 0);

        // Nominal alternation: 8 green phases of 3 cycles, then all-red
        ho = 0;
        for (int p = 0; p < 8; p++) begin
            for (int c = 1; c <= 3; c++) begin
                step((p % 2 == 0) ? c_ns_go : c_ew_go, 1'b0);
                if (c == 1 && p > 0) ho++;
                expect_all("nominal", 0, 0, (p % 2 == 0) ? 1 : 2, c, ho);
            end
        end
        step(c_all_red, 1'b0);
        expect_all("nominal_end", 0, 0, 3, 1, 8);

        // clr_fault outside FAULT has no effect
        step(c_all_red, 1'b1);
        expect_all("clr_ignored", 0, 0, 3, 2, 8);

        // Green held exactly MAX_GREEN is legal
        for (int i = 0; i < 3; i++) step(c_ew_go, 1'b0);
        expect_all("ew3", 0, 0, 2, 3, 9);
        for (int i = 0; i < 8; i++) step(c_ns_go, 1'b0);
        expect_all("ns_max", 0, 0, 1, 8, 10);
        step(c_ew_go, 1'b0);
        expect_all("max_green_ok", 0, 0, 2, 1, 11);

        // Green held MAX_GREEN+1 -> code 4
        step(c_ew_go, 1'b0);
        step(c_ew_go, 1'b0);
        for (int i = 0; i < 8; i++) step(c_ns_go, 1'b0);
        expect_all("ns_8_ok", 0, 0, 1, 8, 12);
        step(c_ns_go, 1'b0);
        expect_all("green_long", 1, 4, 1, 8, 12);

        // Clear, then a 1-cycle green after EW_GO -> code 3
        step(c_ns_go, 1'b1);
        expect_all("clear1", 0, 0, 0, 0, 12);
        for (int i = 0; i < 3; i++) step(c_ew_go, 1'b0);
        expect_all("ew_from_idle", 0, 0, 2, 3, 12);
        step(c_ns_go, 1'b0);
        expect_all("ns_1", 0, 0, 1, 1, 13);
        step(c_ew_go, 1'b0);
        expect_all("green_short", 1, 3, 1, 1, 13);

        // Conflict during EW_GO, sticky through 10 valid cycles
        step(c_ew_go, 1'b1);
        for (int i = 0; i < 3; i++) step(c_ew_go, 1'b0);
        expect_all("ew_pre_conf", 0, 0, 2, 3, 13);
        step(c_conflict, 1'b0);
        expect_all("conflict", 1, 1, 2, 3, 13);
        for (int i = 0; i < 10; i++) begin
            step((i % 2 == 0) ? c_ns_go : c_ew_go, 1'b0);
            expect_all("conflict_hold", 1, 1, 2, 3, 13);
        end

        // Lamp fault, clear while it persists, re-detected from IDLE
        step(c_ew_go, 1'b1);
        step(c_ew_go, 1'b0);
        expect_all("ew_pre_lamp", 0, 0, 2, 1, 13);
        step(c_lamp_bad, 1'b0);
        expect_all("lamp_bad", 1, 2, 2, 1, 13);
        step(c_lamp_bad, 1'b1);
        expect_all("lamp_clr", 0, 0, 0, 0, 13);
        step(c_lamp_bad, 1'b0);
        expect_all("lamp_redetect", 1, 2, 0, 0, 13);

        // Reset while in FAULT
        reset = 1'b1;
        step(c_lamp_bad, 1'b0);
        reset = 1'b0;
        expect_all("reset_in_fault", 0, 0, 0, 0, 0);
        step(c_all_red, 1'b0);
        expect_all("allred_after_rst", 0, 0, 3, 1, 0);

        // All-red bound: MAX_ALLRED legal, one more -> code 5
        for (int i = 0; i < 3; i++) step(c_all_red, 1'b0);
        expect_all("allred_max", 0, 0, 3, 4, 0);
        step(c_all_red, 1'b0);
        expect_all("allred_long", 1, 5, 3, 4, 0);

        // Direct green-to-green handoff
        step(c_all_red, 1'b1);
        expect_all("clear_ar", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(c_ns_go, 1'b0);
        expect_all("ns3", 0, 0, 1, 3, 0);
        step(c_ew_go, 1'b0);
`ifdef TRAFFIC_MON_ALLRED_REQ_EN
        expect_all("g2g_direct", 1, 6, 1, 3, 0);
`else
        expect_all("g2g_direct", 0, 0, 2, 1, 1);
`endif

        // Green-to-green through one all-red cycle is always legal
        do_reset();
        for (int i = 0; i < 3; i++) step(c_ns_go, 1'b0);
        step(c_all_red, 1'b0);
        expect_all("g_ar", 0, 0, 3, 1, 1);
        step(c_ew_go, 1'b0);
        expect_all("g_ar_g", 0, 0, 2, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
